// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and sizing helper for the byte-addressed data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Number of bits needed to represent value (clogb2(31) = 5).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Big-endian lane steering: byte enables, store lane insertion, load extraction/extension
// and the alignment/reserved-size error flag. Lane k is byte address a+k, lane 0 in bits [31:24].
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rbytes,
    output logic [3:0]  be,
    output logic [31:0] wbytes,
    output logic [31:0] rdata,
    output logic        err
);

    always_comb begin
        be     = '0;
        wbytes = '0;
        rdata  = '0;
        err    = 1'b0;
        case (size)
            SZ_BYTE: begin
                be     = 4'b0001;
                wbytes = {wdata[7:0], 24'h0};
                rdata  = {{24{sign_ext & rbytes[31]}}, rbytes[31:24]};
            end
            SZ_HALF: begin
                if (addr_lo[0]) begin
                    err = 1'b1;
                end else begin
                    be     = 4'b0011;
                    wbytes = {wdata[15:0], 16'h0};
                    rdata  = {{16{sign_ext & rbytes[31]}}, rbytes[31:16]};
                end
            end
            SZ_WORD: begin
                if (addr_lo != 2'b00) begin
                    err = 1'b1;
                end else begin
                    be     = 4'b1111;
                    wbytes = wdata;
                    rdata  = rbytes;
                end
            end
            SZ_RSVD: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed big-endian data memory with zero-fill after reset and a fixed-latency
// valid/ready request/response interface.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | zero-fill one word per cycle, busy=1, requests blocked
//   ST_IDLE  | ready to accept a request
//   ST_WAIT  | latency down-counter running; response fires at terminal count
module data_mem_sized
    import dmem_pkg::*;
#(
    parameter  int ENTRIES      = 32,
    parameter  int READ_LATENCY = 1,
    localparam int ADDR_W       = clogb2(ENTRIES - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int WORDS = ENTRIES / 4;
    localparam int CNT_W = ADDR_W - 2;

    logic [7:0] mem [ENTRIES];

    state_t            state, state_nx;
    logic [CNT_W-1:0]  clr_cnt;
    logic [1:0]        lat_cnt;
    logic              accept;
    logic              clr_last;
    logic              lat_done;
    logic              resp_fire;
    logic [31:0]       rbytes;
    logic [31:0]       al_wbytes;
    logic [31:0]       al_rdata;
    logic [3:0]        al_be;
    logic              al_err;
    logic [31:0]       pend_rdata;
    logic              pend_err;

    assign accept   = req_valid && req_ready;
    assign clr_last = (clr_cnt == CNT_W'(WORDS - 1));
    assign lat_done = (lat_cnt == 2'd0);

    assign rbytes = {mem[req_addr],
                     mem[req_addr + ADDR_W'(1)],
                     mem[req_addr + ADDR_W'(2)],
                     mem[req_addr + ADDR_W'(3)]};

    dmem_align u_align (
        .size     (req_size),
        .addr_lo  (req_addr[1:0]),
        .sign_ext (req_signed),
        .wdata    (req_wdata),
        .rbytes   (rbytes),
        .be       (al_be),
        .wbytes   (al_wbytes),
        .rdata    (al_rdata),
        .err      (al_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        resp_fire = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_last) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_done) begin
                    resp_fire = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt    <= '0;
            lat_cnt    <= '0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + CNT_W'(1);
            end
            if (accept) begin
                lat_cnt    <= 2'(READ_LATENCY - 1);
                pend_rdata <= req_wr ? 32'h0 : al_rdata;
                pend_err   <= al_err;
            end else if (state == ST_WAIT && !lat_done) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            resp_valid <= resp_fire;
            if (resp_fire) begin
                resp_rdata <= pend_rdata;
                resp_err   <= pend_err;
            end
        end
    end

    // The array has no reset: an accepted store survives reset until the zero-fill reaches it.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            for (int k = 0; k < 4; k++) begin
                mem[{clr_cnt, 2'b00} + ADDR_W'(k)] <= 8'h00;
            end
        end else if (accept && req_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (al_be[k]) mem[req_addr + ADDR_W'(k)] <= al_wbytes[31-8*k -: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized: vector table on a latency-1 instance plus
// hand-written latency-3, back-to-back and reset-during-wait sequences.
module tb_data_mem_sized;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v1 = 1'b0;
    logic        v3 = 1'b0;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy1, rv1, re1, busy1;
    logic [31:0] rd1;
    logic        rdy3, rv3, re3, busy3;
    logic [31:0] rd3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_mem_sized #(.ENTRIES(32), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1), .busy(busy1)
    );

    data_mem_sized #(.ENTRIES(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(re3), .busy(busy3)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic xact(input bit sel, input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [4:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? rdy3 : rdy1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(sel ? rdy3 : rdy1), 32'd1);
        req_wr = wr;
        req_size = sz;
        req_signed = sgn;
        req_addr = a;
        req_wdata = wd;
        if (sel) v3 = 1'b1;
        else     v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        v3 = 1'b0;
        lat = 0;
        while (!(sel ? rv3 : rv1) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = sel ? rd3 : rd1;
        er = sel ? re3 : re1;
    endtask

    task automatic wait_fill(input string name, output int n, output bit rdy_seen, output bit rv_seen);
        n = 0;
        rdy_seen = 1'b0;
        rv_seen = 1'b0;
        while (busy1 && n < 100) begin
            if (rdy1) rdy_seen = 1'b1;
            if (rv1) rv_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'd8);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        bit          rdy_seen;
        bit          rv_seen;
        int          acc0, acc1, rdy_low, resp0;

        vecs[0]  = '{1'b0, SZ_WORD, 1'b0, 5'd12, 32'h0,        32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, SZ_WORD, 1'b0, 5'd0,  32'h8badf00d, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, SZ_WORD, 1'b0, 5'd0,  32'h0,        32'h8badf00d, 1'b0};
        vecs[3]  = '{1'b0, SZ_BYTE, 1'b0, 5'd1,  32'h0,        32'h000000ad, 1'b0};
        vecs[4]  = '{1'b0, SZ_BYTE, 1'b1, 5'd0,  32'h0,        32'hffffff8b, 1'b0};
        vecs[5]  = '{1'b0, SZ_HALF, 1'b0, 5'd2,  32'h0,        32'h0000f00d, 1'b0};
        vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 5'd2,  32'h0,        32'hfffff00d, 1'b0};
        vecs[7]  = '{1'b1, SZ_BYTE, 1'b0, 5'd5,  32'haaaaaa7f, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, SZ_HALF, 1'b0, 5'd6,  32'hdead1234, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, SZ_WORD, 1'b0, 5'd4,  32'h0,        32'h007f1234, 1'b0};
        vecs[10] = '{1'b0, SZ_HALF, 1'b1, 5'd6,  32'h0,        32'h00001234, 1'b0};
        vecs[11] = '{1'b0, SZ_BYTE, 1'b1, 5'd5,  32'h0,        32'h0000007f, 1'b0};
        vecs[12] = '{1'b0, SZ_WORD, 1'b0, 5'd2,  32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b1, SZ_HALF, 1'b0, 5'd3,  32'h0000ffff, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, SZ_RSVD, 1'b1, 5'd0,  32'h0,        32'h00000000, 1'b1};
        vecs[15] = '{1'b1, SZ_WORD, 1'b0, 5'd1,  32'hffffffff, 32'h00000000, 1'b1};
        vecs[16] = '{1'b0, SZ_WORD, 1'b0, 5'd0,  32'h0,        32'h8badf00d, 1'b0};
        vecs[17] = '{1'b0, SZ_WORD, 1'b0, 5'd4,  32'h0,        32'h007f1234, 1'b0};
        vecs[18] = '{1'b1, SZ_WORD, 1'b0, 5'd28, 32'hcafebabe, 32'h00000000, 1'b0};
        vecs[19] = '{1'b0, SZ_WORD, 1'b0, 5'd28, 32'h0,        32'hcafebabe, 1'b0};
        vecs[20] = '{1'b0, SZ_BYTE, 1'b0, 5'd31, 32'h0,        32'h000000be, 1'b0};
        vecs[21] = '{1'b0, SZ_BYTE, 1'b1, 5'd30, 32'h0,        32'hffffffba, 1'b0};

        // Reset values and zero-fill duration
        repeat (3) @(negedge clk);
        check("rst_ready_valid_err_busy", 32'({rdy1, rv1, re1, busy1}), 32'h1);
        check("rst_rdata", rd1, 32'h0);
        rst_n = 1'b1;
        wait_fill("fill_cycles", n, rdy_seen, rv_seen);
        check("ready_during_fill", 32'(rdy_seen), 32'h0);
        check("dut3_ready_after_fill", 32'({rdy3, busy3}), 32'h2);

        for (int i = 0; i < NV; i++) begin
            xact(1'b0, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end

        // Response registers hold after the pulse
        repeat (3) @(negedge clk);
        check("hold_valid_low", 32'(rv1), 32'h0);
        check("hold_rdata", rd1, 32'hffffffba);

        // Latency-3 instance
        xact(1'b1, 1'b0, SZ_WORD, 1'b0, 5'd0, 32'h0, rd, er, lat);
        check("lat3_latency", 32'(lat), 32'd3);
        check("lat3_rdata", rd, 32'h0);

        @(negedge clk);
        req_wr = 1'b0;
        req_size = SZ_WORD;
        req_addr = 5'd0;
        v3 = 1'b1;
        acc0 = -1;
        acc1 = -1;
        resp0 = -1;
        rdy_low = 0;
        for (int i = 0; i < 9; i++) begin
            if (rv3 && resp0 < 0) resp0 = i;
            if (rdy3) begin
                if (acc0 < 0) acc0 = i;
                else if (acc1 < 0) acc1 = i;
            end else if (acc0 >= 0 && acc1 < 0) begin
                rdy_low++;
            end
            @(negedge clk);
        end
        v3 = 1'b0;
        check("b2b_first_accept", 32'(acc0), 32'd0);
        check("b2b_accept_spacing", 32'(acc1 - acc0), 32'd4);
        check("b2b_ready_low_cycles", 32'(rdy_low), 32'd3);
        check("b2b_resp_cycle", 32'(resp0), 32'd4);

        // Reset asserted while a store waits for its response
        @(negedge clk);
        n = 0;
        while (!rdy1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_wr = 1'b1;
        req_size = SZ_WORD;
        req_addr = 5'd8;
        req_wdata = 32'h11223344;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        check("midrst_in_wait", 32'({rdy1, rv1, busy1}), 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({rdy1, rv1, re1, busy1}), 32'h1);
        check("midrst_rdata", rd1, 32'h0);
        rv_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rv1) rv_seen = 1'b1;
        end
        rst_n = 1'b1;
        wait_fill("refill_cycles", n, rdy_seen, rv_seen);
        check("midrst_no_resp", 32'(rv_seen), 32'h0);
        xact(1'b0, 1'b0, SZ_WORD, 1'b0, 5'd8, 32'h0, rd, er, lat);
        check("midrst_lw8", rd, 32'h0);
        check("midrst_lw8_err", 32'(er), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
